// File: rtl/cpu_pkg.sv
// Shared opcodes, IR field positions and sequencer types for the control sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_RTYPE,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Maps an opcode to its execution class; anything unrecognised executes as a NOP.
module op_classify
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_t  op_class_o
);

    always_comb begin
        op_class_o = CLS_NOP;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: op_class_o = CLS_RTYPE;
            OP_MUL, OP_DIV:                                op_class_o = CLS_MULDIV;
            OP_HALT:                                       op_class_o = CLS_HALT;
            default:                                       op_class_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: one state per cycle, Moore-decoded strobes from state and IR.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  operation,
    output logic        run,
    output state_t      state_o
);

    state_t    state_q, state_d;
    op_class_t class_q, class_d;
    op_class_t op_class;
    state_t    boundary;
    logic      unused_fields;

    // Register fields are routed to the datapath elsewhere; only the opcode matters here.
    assign unused_fields = ^IR[RA_MSB:0];

    op_classify u_op_classify (
        .opcode_i   (IR[OPC_MSB:OPC_LSB]),
        .op_class_o (op_class)
    );

    // Halt requests only take effect where the next state would otherwise be T0.
    assign boundary = stop ? ST_HALT : ST_T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RST;
            class_q <= CLS_NOP;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                class_d = op_class;
                case (op_class)
                    CLS_RTYPE, CLS_MULDIV: state_d = ST_T4;
                    CLS_HALT:              state_d = ST_HALT;
                    default:               state_d = boundary;
                endcase
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (class_q == CLS_MULDIV) ? ST_T6 : boundary;
            ST_T6:   state_d = boundary;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        ZHighout  = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZHIin     = 1'b0;
        ZLOin     = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Read      = 1'b0;
        IncPC     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        operation = 5'b00000;
        run       = 1'b0;
        case (state_q)
            ST_T0: begin
                run       = 1'b1;
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                ZLOin     = 1'b1;
                operation = OP_ADD;
            end
            ST_T1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                run = 1'b1;
                if (op_class == CLS_RTYPE || op_class == CLS_MULDIV) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            ST_T4: begin
                run       = 1'b1;
                Grc       = 1'b1;
                Rout      = 1'b1;
                ZHIin     = 1'b1;
                ZLOin     = 1'b1;
                operation = IR[OPC_MSB:OPC_LSB];
            end
            ST_T5: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                if (class_q == CLS_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            ST_T6: begin
                run      = 1'b1;
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: run = 1'b0;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction expectation queue plus literal spot checks.
module tb_control_sequencer;

    typedef logic [27:0] vec_t;

    localparam int B_ROUT = 0,  B_RIN = 1,   B_GRC = 2,    B_GRB = 3,   B_GRA = 4;
    localparam int B_INCPC = 5, B_READ = 6,  B_LOIN = 7,   B_HIIN = 8,  B_ZLOIN = 9;
    localparam int B_ZHIIN = 10, B_YIN = 11, B_IRIN = 12,  B_MDRIN = 13, B_PCIN = 14;
    localparam int B_MARIN = 15, B_MDROUT = 16, B_ZHOUT = 19, B_ZLOUT = 20;
    localparam int B_PCOUT = 21, B_RUN = 27;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_SUB  = 32'h20918000;
    localparam logic [31:0] IR_MUL  = 32'h78918000;
    localparam logic [31:0] IR_DIV  = 32'h80918000;
    localparam logic [31:0] IR_SHL  = 32'h58918000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        stop;
    logic PCout, Zlowout, ZHighout, HIout, LOout, MDRout;
    logic MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin;
    logic Read, IncPC, Gra, Grb, Grc, Rin, Rout, run;
    logic [4:0] operation;
    cpu_pkg::state_t state_dbg;
    vec_t dut_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .HIout(HIout),
        .LOout(LOout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .ZHIin(ZHIin), .ZLOin(ZLOin), .HIin(HIin), .LOin(LOin),
        .Read(Read), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .operation(operation), .run(run), .state_o(state_dbg)
    );

    assign dut_vec = {run, operation, PCout, Zlowout, ZHighout, HIout, LOout, MDRout,
                      MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin,
                      Read, IncPC, Gra, Grb, Grc, Rin, Rout};

    function automatic vec_t bt(input int b);
        return vec_t'(1) << b;
    endfunction

    function automatic vec_t opf(input logic [4:0] op);
        return {1'b0, op, 22'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of expected output words per instruction ----------------
    typedef enum int {M_RST, M_RUN, M_HALT} mode_t;
    mode_t mode = M_RST;
    vec_t  exp_q[$];
    vec_t  cur = '0;
    bit    model_on = 1'b0;
    bit    need_decode = 1'b0;
    bit    halt_pend = 1'b0;

    task automatic start_instr();
        mode = M_RUN;
        cur = bt(B_RUN) | bt(B_PCOUT) | bt(B_MARIN) | bt(B_INCPC) | bt(B_ZLOIN) | opf(5'b00011);
        exp_q.push_back(bt(B_RUN) | bt(B_ZLOUT) | bt(B_PCIN) | bt(B_READ) | bt(B_MDRIN));
        exp_q.push_back(bt(B_RUN) | bt(B_MDROUT) | bt(B_IRIN));
        need_decode = 1'b1;
    endtask

    task automatic decode(input logic [4:0] opc);
        int cls;
        need_decode = 1'b0;
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b01011: cls = 0;
            5'b01111, 5'b10000: cls = 1;
            5'b11011:           cls = 3;
            default:            cls = 2;
        endcase
        if (cls <= 1) begin
            cur = bt(B_RUN) | bt(B_GRB) | bt(B_ROUT) | bt(B_YIN);
            exp_q.push_back(bt(B_RUN) | bt(B_GRC) | bt(B_ROUT) | bt(B_ZHIIN) | bt(B_ZLOIN) | opf(opc));
            if (cls == 0) begin
                exp_q.push_back(bt(B_RUN) | bt(B_ZLOUT) | bt(B_GRA) | bt(B_RIN));
            end else begin
                exp_q.push_back(bt(B_RUN) | bt(B_ZLOUT) | bt(B_LOIN));
                exp_q.push_back(bt(B_RUN) | bt(B_ZHOUT) | bt(B_HIIN));
            end
        end else begin
            cur = bt(B_RUN);
            halt_pend = (cls == 3);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (clr) begin
                exp_q.delete();
                mode = M_RST;
                cur = '0;
                need_decode = 1'b0;
                halt_pend = 1'b0;
                model_on = 1'b1;
            end else if (mode == M_RST) begin
                start_instr();
            end else if (mode == M_HALT) begin
                cur = '0;
            end else if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
            end else if (need_decode) begin
                decode(IR[31:27]);
            end else if (halt_pend || stop) begin
                mode = M_HALT;
                cur = '0;
                halt_pend = 1'b0;
            end else begin
                start_instr();
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("cycle_outputs", 32'(dut_vec), 32'(cur));
                check("bus_onehot0", 32'($onehot0({PCout, Zlowout, ZHighout, HIout, LOout, MDRout, Rout})), 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset(input int n, input logic [31:0] ir);
        #1;
        clr = 1'b1;
        IR = ir;
        repeat (n) @(negedge clk);
        check("rst_outputs", 32'(dut_vec), 32'd0);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        stop = 1'b0;
        IR = IR_AND;
        repeat (3) @(negedge clk);
        check("rst_all_zero", 32'(dut_vec), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        #1 clr = 1'b0;

        // AND: T0..T5 then T0 again on the seventh cycle
        @(negedge clk);
        check("and_t0_pcout", 32'(PCout), 32'd1);
        repeat (3) @(negedge clk);
        check("and_t3", 32'({Grb, Rout, Yin}), 32'h7);
        @(negedge clk);
        check("and_t4_op", 32'(operation), 32'h05);
        @(negedge clk);
        check("and_t5", 32'({Gra, Rin}), 32'h3);
        @(negedge clk);
        check("and_c7_t0", 32'({PCout, MARin, IncPC}), 32'h7);

        // MUL: T5 low half, T6 high half, eighth cycle is T0
        apply_reset(2, IR_MUL);
        repeat (6) @(negedge clk);
        check("mul_t5", 32'({Zlowout, LOin, Rin}), 32'h6);
        @(negedge clk);
        check("mul_t6", 32'({ZHighout, HIin}), 32'h3);
        @(negedge clk);
        check("mul_c8_t0", 32'(PCout), 32'd1);

        // NOP and unsupported opcode: T3 idle, fifth cycle is T0
        apply_reset(1, IR_NOP);
        repeat (4) @(negedge clk);
        check("nop_t3_idle", 32'(dut_vec), 32'h8000000);
        @(negedge clk);
        check("nop_c5_t0", 32'(PCout), 32'd1);
        apply_reset(1, IR_BAD);
        repeat (4) @(negedge clk);
        check("bad_t3_idle", 32'(dut_vec), 32'h8000000);
        @(negedge clk);
        check("bad_c5_t0", 32'(PCout), 32'd1);

        // stop raised in T4 of ADD: instruction completes, then HALT until clr
        apply_reset(1, IR_ADD);
        repeat (5) @(negedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        check("stop_t5_rin", 32'({run, Rin}), 32'h3);
        @(negedge clk);
        check("stop_halt_run", 32'(run), 32'd0);
        repeat (20) @(negedge clk);
        check("halt_hold", 32'(dut_vec), 32'd0);
        #1 clr = 1'b1;
        @(negedge clk);
        check("halt_clr_rst", 32'(dut_vec), 32'd0);
        #1 clr = 1'b0;
        @(negedge clk);
        check("rst_exit_ignores_stop", 32'(PCout), 32'd1);
        #1 stop = 1'b0;
        repeat (8) @(negedge clk);

        // clr pulse during T4 of SUB
        apply_reset(1, IR_SUB);
        repeat (5) @(negedge clk);
        check("sub_t4_op", 32'(operation), 32'h04);
        #1 clr = 1'b1;
        @(negedge clk);
        check("midclr_rst", 32'(dut_vec), 32'd0);
        #1 clr = 1'b0;
        @(negedge clk);
        check("midclr_t0", 32'({PCout, MARin, IncPC}), 32'h7);

        // HALT opcode
        apply_reset(1, IR_HALT);
        repeat (4) @(negedge clk);
        check("haltop_t3", 32'(dut_vec), 32'h8000000);
        @(negedge clk);
        check("haltop_halted", 32'(run), 32'd0);
        repeat (3) @(negedge clk);

        // stop raised during a NOP fetch halts at the T3 boundary
        apply_reset(1, IR_NOP);
        repeat (2) @(negedge clk);
        #1 stop = 1'b1;
        repeat (3) @(negedge clk);
        check("nop_stop_halt", 32'(run), 32'd0);
        #1 stop = 1'b0;

        // DIV and SHL back-to-back instructions, checked by the model
        apply_reset(1, IR_DIV);
        repeat (16) @(negedge clk);
        apply_reset(1, IR_SHL);
        repeat (14) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
